round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter FRAMES_PER_SEC, default 60, frame ticks per elapsed second.
REQ-002 SHALL have parameter DEATH_FRAMES, default 90, frame ticks spent in DYING.
REQ-003 SHALL have parameter FLASH_FRAMES, default 8, frame ticks per flash_on half-period.
REQ-004 SHALL have parameter DOOR_HOLD_FRAMES, default 30, consecutive frames both players at doors to win.
REQ-005 SHALL have port Clk  in  1  system clock, sole clock, all state on posedge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 SHALL have ports player1_dead, player2_dead  in  1 each  sticky death flags from hazard controllers.
REQ-009 SHALL have ports player1_at_door, player2_at_door  in  1 each  level-sensitive player-at-exit flags.
REQ-010 SHALL have ports start_key, restart_key  in  1 each  raw level key inputs.
REQ-011 SHALL have port hazard_reset  out  1  clears hazard controllers' sticky death flags.
REQ-012 SHALL have port game_state  out  3  current state encoding.
REQ-013 SHALL have ports freeze, flash_on, win, lose  out  1 each  motion freeze, death blink overlay, win and lose indications.
REQ-014 SHALL have port elapsed_seconds  out  10  level time in seconds.

Function
REQ-015 SHALL implement states IDLE=0, LEVEL_INIT=1, PLAYING=2, DYING=3, GAME_OVER=4, WIN=5; all other encodings SHALL return to IDLE on the next clock.
REQ-016 SHALL detect a key press as rising edge = key & ~key_q, where key_q is the key registered once per clock.
REQ-017 IDLE: start_key press -> LEVEL_INIT; restart_key ignored.
REQ-018 LEVEL_INIT: lasts exactly 2 cycles, clears elapsed_seconds, frame, flash and door counters, then -> PLAYING.
REQ-019 hazard_reset SHALL be combinational from state: 1 in IDLE and LEVEL_INIT, else 0.
REQ-020 PLAYING: (player1_dead | player2_dead) -> DYING on the next clock, taking priority over a win in the same cycle.
REQ-021 PLAYING: door counter increments on each frame_tick with both at_door high, clears on any cycle either is low; reaching DOOR_HOLD_FRAMES -> WIN.
REQ-022 PLAYING: a frame counter counts frame_ticks and wraps at FRAMES_PER_SEC, incrementing elapsed_seconds on wrap; elapsed_seconds SHALL saturate at 999.
REQ-023 elapsed_seconds SHALL hold its value in DYING, GAME_OVER and WIN.
REQ-024 DYING: counts DEATH_FRAMES frame_ticks then -> GAME_OVER; flash_on SHALL start at 1 on entry and toggle every FLASH_FRAMES frame_ticks.
REQ-025 flash_on SHALL be 0 outside DYING.
REQ-026 GAME_OVER: lose=1; restart_key press -> LEVEL_INIT.
REQ-027 WIN: win=1; restart_key press -> LEVEL_INIT; start_key ignored.
REQ-028 freeze SHALL be 1 in every state except PLAYING.
REQ-029 frame_tick and a state transition in the same cycle: the tick SHALL be counted by the state being exited only.

Reset
REQ-030 Reset SHALL force state=IDLE and clear all counters and elapsed_seconds; reset outputs SHALL be hazard_reset=1, freeze=1, flash_on=0, win=0, lose=0, game_state=0.
REQ-031 Reset SHALL set key_q=1 for both keys, so a key held through reset does not register a press.
REQ-032 Reset asserted mid-DYING or mid-LEVEL_INIT SHALL abort to IDLE in the same clock edge.

Structure
REQ-033 The state enum game_state_t and the default timing constants SHALL live in shared package fb_game_pkg.
REQ-034 Key edge detection SHALL be one sub-module, edge_detect, instantiated once per key.

Verification
REQ-035 Reset then start_key press -> hazard_reset high for exactly 2 cycles after IDLE exit, state=PLAYING, freeze=0.
REQ-036 PLAYING for 120 frame_ticks, then player2_dead=1 -> elapsed_seconds=2, DYING next clock, flash_on toggles after 8 ticks, GAME_OVER after 90 ticks with lose=1.
REQ-037 Both at_door for 29 ticks, drop for one cycle, then 30 ticks -> WIN only after the second run, win=1, freeze=1.
REQ-038 player1_dead and door counter reaching 30 in the same cycle -> DYING, win stays 0.
REQ-039 Key held through Reset release -> stays IDLE; release and press -> LEVEL_INIT.
REQ-040 Force elapsed_seconds to 999 via 60000+ frame_ticks in PLAYING -> output holds at 999.

Source files
------------

// File: rtl/fb_game_pkg.sv
// Shared game-level types and default timing constants for the round controller.
// Timing values are in video frame ticks unless noted otherwise.
package fb_game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LEVEL_INIT = 3'd1,
    PLAYING    = 3'd2,
    DYING      = 3'd3,
    GAME_OVER  = 3'd4,
    WIN        = 3'd5
  } game_state_t;

  localparam int FB_FRAMES_PER_SEC   = 60;
  localparam int FB_DEATH_FRAMES     = 90;
  localparam int FB_FLASH_FRAMES     = 8;
  localparam int FB_DOOR_HOLD_FRAMES = 30;
  localparam int FB_ELAPSED_MAX      = 999;

  // Saturating increment for the 10-bit seconds display.
  function automatic logic [9:0] sat_inc_seconds(input logic [9:0] v);
    return (v >= 10'(FB_ELAPSED_MAX)) ? 10'(FB_ELAPSED_MAX) : v + 10'd1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a raw level key input.
// Latency: press is combinational from key vs. the key registered one clock earlier.
// Backpressure: none; key_q resets high so a key held through reset is not a press.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic key,
  output logic press
);

  logic key_q;

  always_ff @(posedge Clk) begin
    if (Reset) key_q <= 1'b1;
    else       key_q <= key;
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/round_controller.sv
// Round sequencing FSM: idle, level init, play, dying blink, game over, win.
// Latency: state changes one clock after the triggering input; outputs decode the state flops.
// Backpressure: none; frame_tick pulses are counted only by the state active in that cycle.
module round_controller
  import fb_game_pkg::*;
#(
  parameter int FRAMES_PER_SEC   = FB_FRAMES_PER_SEC,
  parameter int DEATH_FRAMES     = FB_DEATH_FRAMES,
  parameter int FLASH_FRAMES     = FB_FLASH_FRAMES,
  parameter int DOOR_HOLD_FRAMES = FB_DOOR_HOLD_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       player1_dead,
  input  logic       player2_dead,
  input  logic       player1_at_door,
  input  logic       player2_at_door,
  input  logic       start_key,
  input  logic       restart_key,
  output logic       hazard_reset,
  output logic [2:0] game_state,
  output logic       freeze,
  output logic       flash_on,
  output logic       win,
  output logic       lose,
  output logic [9:0] elapsed_seconds
);

  game_state_t state;
  logic        start_press;
  logic        restart_press;
  logic        init_cnt;
  logic [15:0] frame_cnt;
  logic [15:0] death_cnt;
  logic [15:0] flash_cnt;
  logic [15:0] door_cnt;
  logic [9:0]  elapsed;
  logic        flash_q;
  logic        any_dead;
  logic        both_at_door;

  assign any_dead     = player1_dead | player2_dead;
  assign both_at_door = player1_at_door & player2_at_door;

  edge_detect u_start_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .key   (start_key),
    .press (start_press)
  );

  edge_detect u_restart_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .key   (restart_key),
    .press (restart_press)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      init_cnt  <= 1'b0;
      frame_cnt <= '0;
      death_cnt <= '0;
      flash_cnt <= '0;
      door_cnt  <= '0;
      elapsed   <= '0;
      flash_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          flash_q <= 1'b0;
          if (start_press) begin
            state    <= LEVEL_INIT;
            init_cnt <= 1'b0;
          end
        end

        LEVEL_INIT: begin
          frame_cnt <= '0;
          death_cnt <= '0;
          flash_cnt <= '0;
          door_cnt  <= '0;
          elapsed   <= '0;
          flash_q   <= 1'b0;
          if (init_cnt) state <= PLAYING;
          else          init_cnt <= 1'b1;
        end

        PLAYING: begin
          if (frame_tick) begin
            if (frame_cnt == 16'(FRAMES_PER_SEC - 1)) begin
              frame_cnt <= '0;
              elapsed   <= sat_inc_seconds(elapsed);
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          // A death outranks a door win landing in the same cycle.
          if (any_dead) begin
            state     <= DYING;
            death_cnt <= '0;
            flash_cnt <= '0;
            door_cnt  <= '0;
            flash_q   <= 1'b1;
          end else if (!both_at_door) begin
            door_cnt <= '0;
          end else if (frame_tick) begin
            door_cnt <= door_cnt + 16'd1;
            if (door_cnt == 16'(DOOR_HOLD_FRAMES - 1)) state <= WIN;
          end
        end

        DYING: begin
          if (frame_tick) begin
            if (death_cnt == 16'(DEATH_FRAMES - 1)) begin
              state   <= GAME_OVER;
              flash_q <= 1'b0;
            end else begin
              death_cnt <= death_cnt + 16'd1;
              if (flash_cnt == 16'(FLASH_FRAMES - 1)) begin
                flash_cnt <= '0;
                flash_q   <= ~flash_q;
              end else begin
                flash_cnt <= flash_cnt + 16'd1;
              end
            end
          end
        end

        GAME_OVER, WIN: begin
          flash_q <= 1'b0;
          if (restart_press) begin
            state    <= LEVEL_INIT;
            init_cnt <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          flash_q <= 1'b0;
        end
      endcase
    end
  end

  assign game_state      = state;
  assign hazard_reset    = (state == IDLE) || (state == LEVEL_INIT);
  assign freeze          = (state != PLAYING);
  assign win             = (state == WIN);
  assign lose            = (state == GAME_OVER);
  assign flash_on        = flash_q;
  assign elapsed_seconds = elapsed;

endmodule

// File: tb/tb_round_controller.sv
// Bench for round_controller: directed scenarios plus randomized play against a
// tick-accounting reference model (elapsed = total play ticks / 60, blink from death tick count).
module tb_round_controller;
  import fb_game_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       frame_tick;
  logic       player1_dead, player2_dead;
  logic       player1_at_door, player2_at_door;
  logic       start_key, restart_key;
  logic       hazard_reset;
  logic [2:0] game_state;
  logic       freeze, flash_on, win, lose;
  logic [9:0] elapsed_seconds;

  int checks   = 0;
  int failures = 0;

  // Reference model: whole-level tick totals rather than per-field counters.
  logic [2:0] m_state;
  int         m_ticks;
  int         m_door;
  int         m_dticks;
  int         m_init;
  logic       m_start_q, m_restart_q;

  round_controller dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .frame_tick      (frame_tick),
    .player1_dead    (player1_dead),
    .player2_dead    (player2_dead),
    .player1_at_door (player1_at_door),
    .player2_at_door (player2_at_door),
    .start_key       (start_key),
    .restart_key     (restart_key),
    .hazard_reset    (hazard_reset),
    .game_state      (game_state),
    .freeze          (freeze),
    .flash_on        (flash_on),
    .win             (win),
    .lose            (lose),
    .elapsed_seconds (elapsed_seconds)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    logic sp, rp;
    @(posedge Clk);
    sp = start_key && !m_start_q;
    rp = restart_key && !m_restart_q;
    if (Reset) begin
      m_state = IDLE; m_ticks = 0; m_door = 0; m_dticks = 0; m_init = 0;
      m_start_q = 1'b1; m_restart_q = 1'b1;
    end else begin
      m_start_q   = start_key;
      m_restart_q = restart_key;
      case (m_state)
        IDLE: if (sp) begin m_state = LEVEL_INIT; m_init = 0; end
        LEVEL_INIT: begin
          m_init++; m_ticks = 0; m_door = 0;
          if (m_init == 2) m_state = PLAYING;
        end
        PLAYING: begin
          if (frame_tick) m_ticks++;
          if (player1_dead || player2_dead) begin
            m_state = DYING; m_dticks = 0;
          end else if (!(player1_at_door && player2_at_door)) begin
            m_door = 0;
          end else if (frame_tick) begin
            m_door++;
            if (m_door == 30) m_state = WIN;
          end
        end
        DYING: if (frame_tick) begin
          m_dticks++;
          if (m_dticks == 90) m_state = GAME_OVER;
        end
        GAME_OVER, WIN: if (rp) begin m_state = LEVEL_INIT; m_init = 0; end
        default: m_state = IDLE;
      endcase
    end
    #1;
  endtask

  task automatic tick_with_gap(input int max_gap);
    int gap;
    gap = $urandom_range(0, max_gap);
    repeat (gap) step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic restart_level(input logic use_start);
    if (use_start) start_key = 1'b1; else restart_key = 1'b1;
    step();
    start_key = 1'b0; restart_key = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    checks++; if (game_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", game_state); end
    checks++; if (hazard_reset !== 1'b1) begin failures++; $display("FAIL reset_hazard: got %0b expected 1", hazard_reset); end
    checks++; if (freeze !== 1'b1) begin failures++; $display("FAIL reset_freeze: got %0b expected 1", freeze); end
    checks++; if ({flash_on, win, lose} !== 3'b000) begin failures++; $display("FAIL reset_flash_win_lose: got %b expected 000", {flash_on, win, lose}); end
    checks++; if (elapsed_seconds !== 10'd0) begin failures++; $display("FAIL reset_elapsed: got %0d expected 0", elapsed_seconds); end
  endtask

  task automatic test_start();
    int hz_cycles;
    Reset = 1'b0;
    step();
    start_key = 1'b1;
    step();
    start_key = 1'b0;
    hz_cycles = 0;
    for (int i = 0; i < 10 && game_state !== PLAYING; i++) begin
      if (hazard_reset === 1'b1) hz_cycles++;
      step();
    end
    checks++; if (hz_cycles !== 2) begin failures++; $display("FAIL start_hazard_cycles: got %0d expected 2", hz_cycles); end
    checks++; if (game_state !== PLAYING) begin failures++; $display("FAIL start_state: got %0d expected 2", game_state); end
    checks++; if (freeze !== 1'b0 || hazard_reset !== 1'b0) begin failures++; $display("FAIL start_freeze_hazard: got %0b%0b expected 00", freeze, hazard_reset); end
  endtask

  task automatic test_death();
    repeat (120) tick_with_gap(3);
    checks++; if (elapsed_seconds !== 10'd2) begin failures++; $display("FAIL death_elapsed_120: got %0d expected 2", elapsed_seconds); end
    player2_dead = 1'b1;
    step();
    checks++; if (game_state !== DYING || flash_on !== 1'b1) begin failures++; $display("FAIL death_entry: got state %0d flash %0b expected 3/1", game_state, flash_on); end
    for (int i = 1; i <= 90; i++) begin
      tick_with_gap(2);
      if (i == 7 || i == 8 || i == 16 || i == 89) begin
        checks++;
        if (flash_on !== (((i / 8) % 2) == 0)) begin failures++; $display("FAIL death_flash tick=%0d: got %0b expected %0b", i, flash_on, ((i / 8) % 2) == 0); end
      end
      if (i == 89) begin
        checks++; if (game_state !== DYING) begin failures++; $display("FAIL death_still_dying: got %0d expected 3", game_state); end
      end
    end
    checks++; if (game_state !== GAME_OVER || lose !== 1'b1) begin failures++; $display("FAIL death_game_over: got state %0d lose %0b expected 4/1", game_state, lose); end
    checks++; if (elapsed_seconds !== 10'd2 || flash_on !== 1'b0) begin failures++; $display("FAIL death_hold: got elapsed %0d flash %0b expected 2/0", elapsed_seconds, flash_on); end
    player2_dead = 1'b0;
    restart_level(1'b0);
    checks++; if (game_state !== PLAYING || elapsed_seconds !== 10'd0) begin failures++; $display("FAIL restart_playing: got state %0d elapsed %0d expected 2/0", game_state, elapsed_seconds); end
  endtask

  task automatic test_door();
    player1_at_door = 1'b1; player2_at_door = 1'b1;
    repeat (29) tick_with_gap(2);
    player1_at_door = 1'b0;
    step();
    player1_at_door = 1'b1;
    checks++; if (game_state !== PLAYING) begin failures++; $display("FAIL door_29_no_win: got %0d expected 2", game_state); end
    repeat (29) tick_with_gap(2);
    checks++; if (game_state !== PLAYING) begin failures++; $display("FAIL door_second_29: got %0d expected 2", game_state); end
    tick_with_gap(2);
    checks++; if (game_state !== WIN || win !== 1'b1 || freeze !== 1'b1) begin failures++; $display("FAIL door_win: got state %0d win %0b freeze %0b expected 5/1/1", game_state, win, freeze); end
    start_key = 1'b1; step(); start_key = 1'b0; step();
    checks++; if (game_state !== WIN) begin failures++; $display("FAIL win_start_ignored: got %0d expected 5", game_state); end
    player1_at_door = 1'b0; player2_at_door = 1'b0;
    restart_level(1'b0);
    checks++; if (game_state !== PLAYING) begin failures++; $display("FAIL win_restart: got %0d expected 2", game_state); end
  endtask

  task automatic test_dead_vs_win();
    player1_at_door = 1'b1; player2_at_door = 1'b1;
    repeat (29) tick_with_gap(1);
    frame_tick = 1'b1; player1_dead = 1'b1;
    step();
    frame_tick = 1'b0;
    checks++; if (game_state !== DYING || win !== 1'b0) begin failures++; $display("FAIL dead_beats_win: got state %0d win %0b expected 3/0", game_state, win); end
    repeat (5) tick_with_gap(1);
    Reset = 1'b1;
    step();
    checks++; if (game_state !== IDLE || flash_on !== 1'b0) begin failures++; $display("FAIL reset_mid_dying: got state %0d flash %0b expected 0/0", game_state, flash_on); end
    Reset = 1'b0; player1_dead = 1'b0; player1_at_door = 1'b0; player2_at_door = 1'b0;
  endtask

  task automatic test_key_held();
    start_key = 1'b1;
    Reset = 1'b1; step(); step();
    Reset = 1'b0; step(); step();
    checks++; if (game_state !== IDLE) begin failures++; $display("FAIL key_held_through_reset: got %0d expected 0", game_state); end
    restart_key = 1'b1; step(); restart_key = 1'b0; step();
    checks++; if (game_state !== IDLE) begin failures++; $display("FAIL idle_restart_ignored: got %0d expected 0", game_state); end
    start_key = 1'b0; step();
    start_key = 1'b1; step();
    checks++; if (game_state !== LEVEL_INIT) begin failures++; $display("FAIL key_release_press: got %0d expected 1", game_state); end
    Reset = 1'b1; step();
    checks++; if (game_state !== IDLE) begin failures++; $display("FAIL reset_mid_init: got %0d expected 0", game_state); end
    Reset = 1'b0; start_key = 1'b0; step();
  endtask

  task automatic test_random();
    int exp_el;
    restart_level(1'b1);
    for (int c = 0; c < 3000; c++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) player1_at_door = ~player1_at_door;
      if ($urandom_range(0, 49) == 0) player2_at_door = ~player2_at_door;
      if ($urandom_range(0, 19) == 0) start_key = ~start_key;
      if ($urandom_range(0, 19) == 0) restart_key = ~restart_key;
      if (hazard_reset) begin
        player1_dead = 1'b0; player2_dead = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        if ($urandom_range(0, 1) == 0) player1_dead = 1'b1; else player2_dead = 1'b1;
      end
      Reset = ($urandom_range(0, 999) == 0);
      step();
      exp_el = m_ticks / 60;
      if (exp_el > 999) exp_el = 999;
      checks++; if (game_state !== m_state) begin failures++; $display("FAIL rand_state cyc=%0d: got %0d expected %0d", c, game_state, m_state); end
      checks++; if (elapsed_seconds !== 10'(exp_el)) begin failures++; $display("FAIL rand_elapsed cyc=%0d: got %0d expected %0d", c, elapsed_seconds, exp_el); end
      checks++; if (flash_on !== (m_state == DYING && ((m_dticks / 8) % 2) == 0)) begin failures++; $display("FAIL rand_flash cyc=%0d: got %0b dticks %0d", c, flash_on, m_dticks); end
      checks++; if (hazard_reset !== (m_state == IDLE || m_state == LEVEL_INIT)) begin failures++; $display("FAIL rand_hazard cyc=%0d: got %0b state %0d", c, hazard_reset, m_state); end
      checks++; if (freeze !== (m_state != PLAYING)) begin failures++; $display("FAIL rand_freeze cyc=%0d: got %0b state %0d", c, freeze, m_state); end
      checks++; if ({win, lose} !== {m_state == WIN, m_state == GAME_OVER}) begin failures++; $display("FAIL rand_win_lose cyc=%0d: got %b state %0d", c, {win, lose}, m_state); end
    end
    Reset = 1'b0; frame_tick = 1'b0; start_key = 1'b0; restart_key = 1'b0;
    player1_dead = 1'b0; player2_dead = 1'b0; player1_at_door = 1'b0; player2_at_door = 1'b0;
  endtask

  task automatic test_saturation();
    Reset = 1'b1; step(); Reset = 1'b0; step();
    restart_level(1'b1);
    frame_tick = 1'b1;
    for (int i = 1; i <= 60100; i++) begin
      step();
      if (i == 59939) begin
        checks++; if (elapsed_seconds !== 10'd998) begin failures++; $display("FAIL sat_998: got %0d expected 998", elapsed_seconds); end
      end
      if (i == 59940) begin
        checks++; if (elapsed_seconds !== 10'd999) begin failures++; $display("FAIL sat_999: got %0d expected 999", elapsed_seconds); end
      end
    end
    frame_tick = 1'b0;
    checks++; if (elapsed_seconds !== 10'd999 || game_state !== PLAYING) begin failures++; $display("FAIL sat_hold: got elapsed %0d state %0d expected 999/2", elapsed_seconds, game_state); end
  endtask

  initial begin
    Reset = 1'b1; frame_tick = 1'b0;
    player1_dead = 1'b0; player2_dead = 1'b0;
    player1_at_door = 1'b0; player2_at_door = 1'b0;
    start_key = 1'b0; restart_key = 1'b0;
    m_state = IDLE; m_ticks = 0; m_door = 0; m_dticks = 0; m_init = 0;
    m_start_q = 1'b1; m_restart_q = 1'b1;
    test_reset();
    test_start();
    test_death();
    test_door();
    test_dead_vs_win();
    test_key_held();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
